// File: rtl/fc_mac_unit.sv
// fc_mac_unit
// Serial fixed-point multiply-accumulate for the FC layer. Takes a stream of
// signed Q5.11 (activation, weight) pairs, multiplies each pair with a
// one-bit-per-cycle shift-add multiplier, and sums the exact Q10.22 products
// into a saturating 32-bit accumulator. When the pair flagged as last has
// been accumulated, the Q10.22 dot product and a saturation flag are held on
// the output until the downstream truncation stage takes them.

module fc_mac_unit #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 11,
   parameter int ACC_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_w,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_acc,
   output logic              out_sat,
   output logic              busy
);

   // The product of two Q5.11 values is Q10.22, so the accumulator must be
   // exactly twice the operand width for the fraction point to line up.
   localparam int PROD_FRAC_W = 2 * FRAC_W;

   // Elaboration guard against parameter sets the datapath cannot represent.
   if ((ACC_W != 2 * DATA_W) || (PROD_FRAC_W >= ACC_W)) begin : g_illegalParams
      $error("fc_mac_unit: ACC_W must equal 2*DATA_W and 2*FRAC_W must be below ACC_W");
   end

   // One multiplier bit is consumed per cycle, so MUL lasts DATA_W cycles.
   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   // Most positive / most negative accumulator values used when clamping.
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_ACC,
      S_OUT
   } state_t;

   state_t              r_state;
   logic [ACC_W-1:0]    r_mcand;
   logic [DATA_W:0]     r_mplier;
   logic [ACC_W-1:0]    r_prod;
   logic                r_sign;
   logic                r_last;
   logic [CNT_W-1:0]    r_cnt;
   logic [ACC_W-1:0]    r_acc;
   logic                r_sat;
   logic                r_outValid;
   logic [ACC_W-1:0]    r_outAcc;
   logic                r_outSat;

   logic [DATA_W:0]     w_aExt;
   logic [DATA_W:0]     w_wExt;
   logic [DATA_W:0]     w_aMag;
   logic [DATA_W:0]     w_wMag;
   logic [ACC_W-1:0]    w_partial;
   logic [ACC_W-1:0]    w_prodSigned;
   logic [ACC_W:0]      w_sum;
   logic                w_posOvf;
   logic                w_negOvf;
   logic [ACC_W-1:0]    w_accNext;
   logic                w_satNow;
   logic                w_accept;

   // Operand magnitudes are formed one bit wider than the input so that the
   // most negative value (-16.0) has an exact positive magnitude.
   always_comb begin
      w_aExt = {in_a[DATA_W-1], in_a};
      w_wExt = {in_w[DATA_W-1], in_w};
      w_aMag = w_aExt;
      w_wMag = w_wExt;
      if (in_a[DATA_W-1]) begin
         w_aMag = ~w_aExt + 1'b1;
      end
      if (in_w[DATA_W-1]) begin
         w_wMag = ~w_wExt + 1'b1;
      end
   end

   // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      w_partial = '0;
      if (r_mplier[0]) begin
         w_partial = r_mcand;
      end
   end

   // Apply the product sign, then add at one extra bit so overflow in either
   // direction is visible and can be clamped instead of wrapping.
   always_comb begin
      w_prodSigned = r_prod;
      if (r_sign) begin
         w_prodSigned = ~r_prod + 1'b1;
      end
      w_sum     = {r_acc[ACC_W-1], r_acc} + {w_prodSigned[ACC_W-1], w_prodSigned};
      w_posOvf  = ~w_sum[ACC_W] & w_sum[ACC_W-1];
      w_negOvf  = w_sum[ACC_W] & ~w_sum[ACC_W-1];
      w_satNow  = w_posOvf | w_negOvf;
      w_accNext = w_sum[ACC_W-1:0];
      if (w_posOvf) begin
         w_accNext = ACC_MAX;
      end else if (w_negOvf) begin
         w_accNext = ACC_MIN;
      end
   end

   // Input handshake: only IDLE accepts, and never while reset is asserted.
   always_comb begin
      in_ready = (r_state == S_IDLE) && !rst;
      w_accept = in_valid && in_ready;
   end

   // Main controller: capture a pair, run the serial multiply, accumulate,
   // and present the finished dot product until the downstream takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_prod     <= '0;
         r_sign     <= 1'b0;
         r_last     <= 1'b0;
         r_cnt      <= '0;
         r_acc      <= '0;
         r_sat      <= 1'b0;
         r_outValid <= 1'b0;
         r_outAcc   <= '0;
         r_outSat   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mcand  <= {{(ACC_W-DATA_W-1){1'b0}}, w_aMag};
                  r_mplier <= w_wMag;
                  r_prod   <= '0;
                  r_sign   <= in_a[DATA_W-1] ^ in_w[DATA_W-1];
                  r_last   <= in_last;
                  r_cnt    <= '0;
                  r_state  <= S_MUL;
               end
            end
            S_MUL: begin
               r_prod   <= r_prod + w_partial;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_state <= S_ACC;
               end
            end
            S_ACC: begin
               r_acc <= w_accNext;
               r_sat <= r_sat | w_satNow;
               if (r_last) begin
                  r_outValid <= 1'b1;
                  r_outAcc   <= w_accNext;
                  r_outSat   <= r_sat | w_satNow;
                  r_state    <= S_OUT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_acc      <= '0;
                  r_sat      <= 1'b0;
                  r_outValid <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Registered outputs and status.
   always_comb begin
      out_valid = r_outValid;
      out_acc   = r_outAcc;
      out_sat   = r_outSat;
      busy      = (r_state != S_IDLE);
   end

endmodule
